// File: rtl/n64adv2_vout_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : n64adv2_vout_timing_gen
// Purpose  : HDMI-domain raster timing (HSYNC/VSYNC/DE) and scaler line-fetch
//            requests, with config shadowed at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module n64adv2_vout_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int REQ_LEAD = 2
) (
  input  logic             HDMI_CLK_w,
  input  logic             HDMI_nRST_w,
  input  logic             nresync_i,
  input  logic [CNT_W-1:0] h_act_i,
  input  logic [CNT_W-1:0] h_fp_i,
  input  logic [CNT_W-1:0] h_sync_i,
  input  logic [CNT_W-1:0] h_bp_i,
  input  logic [CNT_W-1:0] v_act_i,
  input  logic [CNT_W-1:0] v_fp_i,
  input  logic [CNT_W-1:0] v_sync_i,
  input  logic [CNT_W-1:0] v_bp_i,
  input  logic             hs_pol_i,
  input  logic             vs_pol_i,
  output logic             HSYNC_o,
  output logic             VSYNC_o,
  output logic             DE_o,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             frame_start_o,
  output logic             line_req_o,
  output logic [CNT_W-1:0] line_req_idx_o,
  output logic             cfg_err_o
);

  localparam int              c_W1   = CNT_W + 1;
  localparam logic [c_W1-1:0] c_LEAD = REQ_LEAD[c_W1-1:0];

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;
  localparam logic [1:0] c_ERR  = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_h_act, r_h_fp, r_h_sync, r_h_bp;
  logic [CNT_W-1:0] r_v_act, r_v_fp, r_v_sync, r_v_bp;
  logic             r_hs_pol, r_vs_pol;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             r_cfg_err;
  logic             r_hs, r_vs, r_de, r_fs, r_req;
  logic [CNT_W-1:0] r_h_out, r_v_out, r_req_idx;

  // Legality is judged two bits wider so a four-term sum can never wrap into range
  function automatic logic axis_legal(input logic [CNT_W-1:0] act, fp, sync, bp);
    logic [CNT_W+1:0] tot;
    tot = {2'b00, act} + {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
    return (act != '0) && (sync != '0) && (tot <= {2'b00, {CNT_W{1'b1}}});
  endfunction

  logic w_in_legal;
  assign w_in_legal = axis_legal(h_act_i, h_fp_i, h_sync_i, h_bp_i) &&
                      axis_legal(v_act_i, v_fp_i, v_sync_i, v_bp_i);

  logic [c_W1-1:0] w_h_tot, w_v_tot, w_hs_beg, w_hs_end, w_vs_beg, w_vs_end;
  logic [c_W1-1:0] w_h, w_v;
  assign w_h      = {1'b0, r_h_cnt};
  assign w_v      = {1'b0, r_v_cnt};
  assign w_hs_beg = {1'b0, r_h_act} + {1'b0, r_h_fp};
  assign w_hs_end = w_hs_beg + {1'b0, r_h_sync};
  assign w_h_tot  = w_hs_end + {1'b0, r_h_bp};
  assign w_vs_beg = {1'b0, r_v_act} + {1'b0, r_v_fp};
  assign w_vs_end = w_vs_beg + {1'b0, r_v_sync};
  assign w_v_tot  = w_vs_end + {1'b0, r_v_bp};

  logic w_h_last, w_v_last, w_frame_end, w_run;
  assign w_h_last    = (w_h == w_h_tot - 1'b1);
  assign w_v_last    = (w_v == w_v_tot - 1'b1);
  assign w_frame_end = (r_state == c_RUN) && w_h_last && w_v_last;
  assign w_run       = (r_state == c_RUN) && nresync_i;

  // Target line wraps into the next frame so its first lines are fetched in vblank
  logic [c_W1-1:0] w_tgt;
  always_comb begin
    w_tgt = w_v + c_LEAD;
    for (int i = 0; i < REQ_LEAD; i++) begin
      if (w_tgt >= w_v_tot) w_tgt = w_tgt - w_v_tot;
    end
  end

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) r_state <= c_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!nresync_i) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  w_state_nxt = c_LOAD;
        c_LOAD:  w_state_nxt = w_in_legal ? c_RUN : c_ERR;
        c_RUN:   if (w_frame_end && !w_in_legal) w_state_nxt = c_ERR;
        c_ERR:   if (w_in_legal) w_state_nxt = c_LOAD;
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  logic             w_de_nxt, w_hs_nxt, w_vs_nxt, w_fs_nxt, w_req_nxt;
  logic [CNT_W-1:0] w_h_out, w_v_out;
  always_comb begin
    w_de_nxt  = 1'b0;
    w_hs_nxt  = ~r_hs_pol;
    w_vs_nxt  = ~r_vs_pol;
    w_fs_nxt  = 1'b0;
    w_req_nxt = 1'b0;
    w_h_out   = '0;
    w_v_out   = '0;
    if (w_run) begin
      w_de_nxt  = (r_h_cnt < r_h_act) && (r_v_cnt < r_v_act);
      w_hs_nxt  = ((w_h >= w_hs_beg) && (w_h < w_hs_end)) ? r_hs_pol : ~r_hs_pol;
      w_vs_nxt  = ((w_v >= w_vs_beg) && (w_v < w_vs_end)) ? r_vs_pol : ~r_vs_pol;
      w_fs_nxt  = (r_h_cnt == '0) && (r_v_cnt == '0);
      w_req_nxt = (r_h_cnt == r_h_act) && (w_tgt < {1'b0, r_v_act});
      w_h_out   = r_h_cnt;
      w_v_out   = r_v_cnt;
    end
  end

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      {r_h_act, r_h_fp, r_h_sync, r_h_bp} <= '0;
      {r_v_act, r_v_fp, r_v_sync, r_v_bp} <= '0;
      r_hs_pol  <= 1'b0;
      r_vs_pol  <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (nresync_i && ((r_state == c_LOAD) || w_frame_end)) begin
        {r_h_act, r_h_fp, r_h_sync, r_h_bp} <= {h_act_i, h_fp_i, h_sync_i, h_bp_i};
        {r_v_act, r_v_fp, r_v_sync, r_v_bp} <= {v_act_i, v_fp_i, v_sync_i, v_bp_i};
        r_hs_pol  <= hs_pol_i;
        r_vs_pol  <= vs_pol_i;
        r_cfg_err <= ~w_in_legal;
      end else if (nresync_i && (r_state == c_ERR) && w_in_legal) begin
        r_cfg_err <= 1'b0;
      end
      if ((r_state == c_RUN) && (w_state_nxt == c_RUN)) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= '0;
        r_v_cnt <= '0;
      end
    end
  end

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      {r_hs, r_vs, r_de, r_fs, r_req} <= '0;
      r_h_out   <= '0;
      r_v_out   <= '0;
      r_req_idx <= '0;
    end else begin
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_de    <= w_de_nxt;
      r_fs    <= w_fs_nxt;
      r_req   <= w_req_nxt;
      r_h_out <= w_h_out;
      r_v_out <= w_v_out;
      if (w_req_nxt) r_req_idx <= w_tgt[CNT_W-1:0];
    end
  end

  assign HSYNC_o        = r_hs;
  assign VSYNC_o        = r_vs;
  assign DE_o           = r_de;
  assign h_cnt_o        = r_h_out;
  assign v_cnt_o        = r_v_out;
  assign frame_start_o  = r_fs;
  assign line_req_o     = r_req;
  assign line_req_idx_o = r_req_idx;
  assign cfg_err_o      = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_n64adv2_vout_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64adv2_vout_timing_gen
// Purpose  : Directed self-checking bench for the raster timing generator,
//            using small rasters so several frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64adv2_vout_timing_gen;
  localparam int CNT_W    = 12;
  localparam int REQ_LEAD = 2;

  logic             HDMI_CLK_w = 1'b0;
  logic             HDMI_nRST_w = 1'b1;
  logic             nresync_i = 1'b0;
  logic [CNT_W-1:0] h_act_i, h_fp_i, h_sync_i, h_bp_i;
  logic [CNT_W-1:0] v_act_i, v_fp_i, v_sync_i, v_bp_i;
  logic             hs_pol_i, vs_pol_i;
  logic             HSYNC_o, VSYNC_o, DE_o, frame_start_o, line_req_o, cfg_err_o;
  logic [CNT_W-1:0] h_cnt_o, v_cnt_o, line_req_idx_o;

  n64adv2_vout_timing_gen #(.CNT_W(CNT_W), .REQ_LEAD(REQ_LEAD)) dut (
    .HDMI_CLK_w(HDMI_CLK_w), .HDMI_nRST_w(HDMI_nRST_w), .nresync_i(nresync_i),
    .h_act_i(h_act_i), .h_fp_i(h_fp_i), .h_sync_i(h_sync_i), .h_bp_i(h_bp_i),
    .v_act_i(v_act_i), .v_fp_i(v_fp_i), .v_sync_i(v_sync_i), .v_bp_i(v_bp_i),
    .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
    .h_cnt_o(h_cnt_o), .v_cnt_o(v_cnt_o), .frame_start_o(frame_start_o),
    .line_req_o(line_req_o), .line_req_idx_o(line_req_idx_o), .cfg_err_o(cfg_err_o)
  );

  always #5 HDMI_CLK_w = ~HDMI_CLK_w;

  typedef struct packed {int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;} cfg_t;

  // A: h_tot 10 (sync at 6..7), v_tot 6 (vsync on line 4), active-high
  // B: h_tot 6 (sync at 4), v_tot 6 (vsync on line 3), active-low
  localparam cfg_t c_CFG_A = '{4, 2, 2, 2, 3, 1, 1, 1, 1, 1};
  localparam cfg_t c_CFG_B = '{3, 1, 1, 1, 2, 1, 1, 2, 0, 0};

  int   vecs = 0;
  int   errs = 0;
  int   bh, bv, reqs;
  cfg_t m, p, c_bad;

  task automatic tick();
    @(posedge HDMI_CLK_w);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d (pos h=%0d v=%0d)", tag, obs, exp, bh, bv);
    end
  endtask

  task automatic drive(input cfg_t c);
    h_act_i  = c.ha[CNT_W-1:0];
    h_fp_i   = c.hf[CNT_W-1:0];
    h_sync_i = c.hs[CNT_W-1:0];
    h_bp_i   = c.hb[CNT_W-1:0];
    v_act_i  = c.va[CNT_W-1:0];
    v_fp_i   = c.vf[CNT_W-1:0];
    v_sync_i = c.vs[CNT_W-1:0];
    v_bp_i   = c.vb[CNT_W-1:0];
    hs_pol_i = c.hp[0];
    vs_pol_i = c.vp[0];
  endtask

  // Each tick shows raster position (bh,bv) of the frame config m; p is
  // the config the bench expects to take effect at the next frame start.
  task automatic run_model(input int n);
    int   ht, vt, t;
    logic e_de, e_hs, e_vs, e_req;
    for (int k = 0; k < n; k++) begin
      tick();
      ht    = m.ha + m.hf + m.hs + m.hb;
      vt    = m.va + m.vf + m.vs + m.vb;
      e_de  = (bh < m.ha) && (bv < m.va);
      e_hs  = (bh >= m.ha + m.hf && bh < m.ha + m.hf + m.hs) ? m.hp[0] : ~m.hp[0];
      e_vs  = (bv >= m.va + m.vf && bv < m.va + m.vf + m.vs) ? m.vp[0] : ~m.vp[0];
      t     = (bv + REQ_LEAD) % vt;
      e_req = (bh == m.ha) && (t < m.va);
      chk("DE_o", DE_o, e_de);
      chk("HSYNC_o", HSYNC_o, e_hs);
      chk("VSYNC_o", VSYNC_o, e_vs);
      chk("h_cnt_o", h_cnt_o, bh);
      chk("v_cnt_o", v_cnt_o, bv);
      chk("frame_start_o", frame_start_o, (bh == 0 && bv == 0));
      chk("line_req_o", line_req_o, e_req);
      if (e_req) chk("line_req_idx_o", line_req_idx_o, t);
      if (line_req_o === 1'b1) reqs++;
      bh++;
      if (bh == ht) begin
        bh = 0;
        bv++;
        if (bv == vt) begin
          bv = 0;
          m  = p;
        end
      end
    end
  endtask

  initial begin
    bh = 0; bv = 0; reqs = 0;
    m = c_CFG_A; p = c_CFG_A;
    drive(c_CFG_A);

    // Asynchronous reset: every output cleared without a clock edge
    #2 HDMI_nRST_w = 1'b0;
    #1;
    chk("rst DE_o", DE_o, 0);
    chk("rst HSYNC_o", HSYNC_o, 0);
    chk("rst VSYNC_o", VSYNC_o, 0);
    chk("rst cfg_err_o", cfg_err_o, 0);
    chk("rst frame_start_o", frame_start_o, 0);
    chk("rst line_req_idx_o", line_req_idx_o, 0);
    tick(); tick();
    HDMI_nRST_w = 1'b1;

    // IDLE: syncs sit at the inverse of the (zeroed) shadow polarity
    tick(); tick();
    chk("idle HSYNC_o", HSYNC_o, 1);
    chk("idle VSYNC_o", VSYNC_o, 1);
    chk("idle DE_o", DE_o, 0);
    chk("idle h_cnt_o", h_cnt_o, 0);

    // Start: one LOAD cycle, RUN at (0,0), first outputs one cycle later
    nresync_i = 1'b1;
    tick();
    tick();
    chk("load DE_o", DE_o, 0);
    chk("load frame_start_o", frame_start_o, 0);
    reqs = 0;
    run_model(120);
    chk("two-frame line_req count", reqs, 6);

    // Mid-frame switch: A frame finishes, B takes over at the next (0,0)
    run_model(25);
    drive(c_CFG_B);
    p = c_CFG_B;
    run_model(71);

    // Drop nresync mid-frame: outputs inactive on the very next cycle
    run_model(15);
    nresync_i = 1'b0;
    tick();
    chk("drop DE_o", DE_o, 0);
    chk("drop HSYNC_o", HSYNC_o, 1);
    chk("drop VSYNC_o", VSYNC_o, 1);
    chk("drop h_cnt_o", h_cnt_o, 0);
    chk("drop v_cnt_o", v_cnt_o, 0);
    chk("drop frame_start_o", frame_start_o, 0);
    tick();
    nresync_i = 1'b1;
    tick();
    tick();
    bh = 0; bv = 0;
    run_model(36);

    // Illegal h_act: the current frame completes, then ERR
    c_bad    = c_CFG_B;
    c_bad.ha = 0;
    drive(c_bad);
    p = c_bad;
    run_model(36);
    chk("err cfg_err_o set", cfg_err_o, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("err DE_o", DE_o, 0);
      chk("err cfg_err_o held", cfg_err_o, 1);
    end

    // Legal config again: error clears, LOAD, fresh frame from (0,0)
    drive(c_CFG_A);
    tick();
    chk("recover cfg_err_o", cfg_err_o, 0);
    tick();
    chk("recover load DE_o", DE_o, 0);
    m = c_CFG_A; p = c_CFG_A; bh = 0; bv = 0;
    run_model(60);

    // Reset mid-line while DE is high
    run_model(13);
    chk("pre-reset DE_o", DE_o, 1);
    #2 HDMI_nRST_w = 1'b0;
    #1;
    chk("midline rst DE_o", DE_o, 0);
    chk("midline rst HSYNC_o", HSYNC_o, 0);
    chk("midline rst VSYNC_o", VSYNC_o, 0);
    chk("midline rst h_cnt_o", h_cnt_o, 0);
    chk("midline rst v_cnt_o", v_cnt_o, 0);
    chk("midline rst line_req_o", line_req_o, 0);
    chk("midline rst line_req_idx_o", line_req_idx_o, 0);
    chk("midline rst cfg_err_o", cfg_err_o, 0);
    nresync_i = 1'b0;
    tick();
    HDMI_nRST_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post-rst idle DE_o", DE_o, 0);
      chk("post-rst idle frame_start_o", frame_start_o, 0);
    end
    nresync_i = 1'b1;
    tick();
    tick();
    bh = 0; bv = 0;
    run_model(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
